// File: rtl/sdrctrl_package.sv
// Shared widths, FSM encoding and tag-FIFO entry layout for the SDRAM application request bridge.
package sdrctrl_package;

    localparam int aw = 26;
    localparam int dw = 32;
    localparam int tw = 8;
    localparam int bl = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_ISSUE = 2'd2
    } state_e;

    typedef struct packed {
        logic [tw-1:0] tag;
        logic          is_final;
    } tag_entry_t;

    // Largest burst that fits the remaining count, the burst cap and the rest of the page.
    function automatic logic [bl-1:0] burst_len(input int rem, input int page_off,
                                                input int max_burst, input int col_words);
        int n;
        n = rem;
        if (n > max_burst) n = max_burst;
        if (n > col_words - page_off) n = col_words - page_off;
        return bl'(n);
    endfunction

endpackage

// File: rtl/sdr_app_req_bridge_if.sv
// Controller-side application interface: burst request, write-data pull and read return.
interface sdr_app_req_bridge_if;
    import sdrctrl_package::*;

    logic          app_req;
    logic [aw-1:0] app_req_addr;
    logic [bl-1:0] app_req_len;
    logic          app_req_wr_n;
    logic          app_req_ack;
    logic [dw-1:0] app_wr_data;
    logic          app_wr_next_req;
    logic [dw-1:0] app_rd_data;
    logic          app_rd_valid;
    logic          app_last_rd;

    modport master (
        output app_req, app_req_addr, app_req_len, app_req_wr_n, app_wr_data,
        input  app_req_ack, app_wr_next_req, app_rd_data, app_rd_valid, app_last_rd
    );

    modport slave (
        input  app_req, app_req_addr, app_req_len, app_req_wr_n, app_wr_data,
        output app_req_ack, app_wr_next_req, app_rd_data, app_rd_valid, app_last_rd
    );

endinterface

// File: rtl/sdr_tag_fifo.sv
// Synchronous FIFO of outstanding read-burst tags; a pop frees its slot for a push in the same cycle.
module sdr_tag_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem_q[rd_ptr_q];

    // NOTE: every variable gets its default before any branch so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: synchronous reset; state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; count_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/sdr_app_req_bridge.sv
// Splits tagged host transactions into page-safe controller bursts and tags the returning read data.
module sdr_app_req_bridge
    import sdrctrl_package::*;
#(
    parameter int MAX_BURST = 16,
    parameter int COL_WORDS = 256,
    parameter int TAG_DEPTH = 4
) (
    input  logic          sdram_clk,
    input  logic          reset,
    input  logic          h_req_valid,
    output logic          h_req_ready,
    input  logic [aw-1:0] h_req_addr,
    input  logic [7:0]    h_req_len,
    input  logic          h_req_wr,
    input  logic [tw-1:0] h_req_tag,
    input  logic [dw-1:0] h_wr_data,
    output logic          h_wr_next,
    output logic [dw-1:0] h_rd_data,
    output logic          h_rd_valid,
    output logic [tw-1:0] h_rd_tag,
    output logic          h_rd_last,
    output logic          err_orphan_rd,
    sdr_app_req_bridge_if.master app
);

    localparam logic [1:0]    IDLE     = ST_IDLE;
    localparam logic [1:0]    CALC     = ST_CALC;
    localparam logic [1:0]    ISSUE    = ST_ISSUE;
    localparam logic [aw-1:0] COL_MASK = aw'(COL_WORDS - 1);

    logic [1:0]    state_q, state_d;
    logic          ready_q, ready_d;
    logic [aw-1:0] addr_q, addr_d;
    logic [8:0]    rem_q, rem_d;
    logic          wr_q, wr_d;
    logic [tw-1:0] tag_q, tag_d;
    logic [aw-1:0] req_addr_q, req_addr_d;
    logic [bl-1:0] req_len_q, req_len_d;
    logic          req_wr_n_q, req_wr_n_d;
    logic          err_q, err_d;

    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic          app_req_c, ack_fire, burst_final;
    tag_entry_t    push_entry, head_entry;
    logic [$bits(tag_entry_t)-1:0] head_bits;

    // A full tag FIFO stalls reads unless the head is retiring in this very cycle.
    assign fifo_pop    = app.app_rd_valid & app.app_last_rd & ~fifo_empty;
    assign app_req_c   = (state_q == ISSUE) & (wr_q | ~fifo_full | fifo_pop);
    assign ack_fire    = app_req_c & app.app_req_ack;
    assign burst_final = (rem_q == 9'(req_len_q));
    assign fifo_push   = ack_fire & ~wr_q;
    assign push_entry  = '{tag: tag_q, is_final: burst_final};
    assign head_entry  = tag_entry_t'(head_bits);

    sdr_tag_fifo #(
        .WIDTH ($bits(tag_entry_t)),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk       (sdram_clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (head_bits),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        wr_d       = wr_q;
        tag_d      = tag_q;
        req_addr_d = req_addr_q;
        req_len_d  = req_len_q;
        req_wr_n_d = req_wr_n_q;
        err_d      = err_q | (app.app_rd_valid & fifo_empty);
        case (state_q)
            IDLE: begin
                if (h_req_valid && ready_q) begin
                    addr_d  = h_req_addr;
                    rem_d   = 9'(h_req_len) + 9'd1;
                    wr_d    = h_req_wr;
                    tag_d   = h_req_tag;
                    state_d = CALC;
                end
            end
            CALC: begin
                req_addr_d = addr_q;
                req_len_d  = burst_len(int'(rem_q), int'(addr_q & COL_MASK), MAX_BURST, COL_WORDS);
                req_wr_n_d = ~wr_q;
                state_d    = ISSUE;
            end
            ISSUE: begin
                if (ack_fire) begin
                    addr_d  = addr_q + aw'(req_len_q);
                    rem_d   = rem_q - 9'(req_len_q);
                    state_d = burst_final ? IDLE : CALC;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge sdram_clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ready_q    <= 1'b0;
            addr_q     <= '0;
            rem_q      <= '0;
            wr_q       <= 1'b0;
            tag_q      <= '0;
            req_addr_q <= '0;
            req_len_q  <= '0;
            req_wr_n_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            wr_q       <= wr_d;
            tag_q      <= tag_d;
            req_addr_q <= req_addr_d;
            req_len_q  <= req_len_d;
            req_wr_n_q <= req_wr_n_d;
            err_q      <= err_d;
        end
    end

    assign h_req_ready      = ready_q;
    assign err_orphan_rd    = err_q;
    assign h_wr_next        = app.app_wr_next_req;
    assign app.app_wr_data  = h_wr_data;
    assign app.app_req      = app_req_c;
    assign app.app_req_addr = req_addr_q;
    assign app.app_req_len  = req_len_q;
    assign app.app_req_wr_n = req_wr_n_q;

    assign h_rd_data  = app.app_rd_data;
    assign h_rd_valid = app.app_rd_valid & ~fifo_empty;
    assign h_rd_tag   = fifo_empty ? '0 : head_entry.tag;
    assign h_rd_last  = h_rd_valid & app.app_last_rd & head_entry.is_final;

endmodule

// File: tb/tb_sdr_app_req_bridge.sv
// Random controller/host environment with a transaction-level burst and read-return scoreboard.
module tb_sdr_app_req_bridge;
    import sdrctrl_package::*;

    localparam int MAX_BURST = 16;
    localparam int COL_WORDS = 256;
    localparam int TAG_DEPTH = 4;

    logic          sdram_clk = 1'b0;
    logic          reset = 1'b1;
    logic          h_req_valid, h_req_ready, h_req_wr, h_wr_next;
    logic [aw-1:0] h_req_addr;
    logic [7:0]    h_req_len;
    logic [tw-1:0] h_req_tag, h_rd_tag;
    logic [dw-1:0] h_wr_data, h_rd_data;
    logic          h_rd_valid, h_rd_last, err_orphan_rd;

    sdr_app_req_bridge_if bus ();

    sdr_app_req_bridge #(
        .MAX_BURST (MAX_BURST),
        .COL_WORDS (COL_WORDS),
        .TAG_DEPTH (TAG_DEPTH)
    ) dut (
        .sdram_clk     (sdram_clk),
        .reset         (reset),
        .h_req_valid   (h_req_valid),
        .h_req_ready   (h_req_ready),
        .h_req_addr    (h_req_addr),
        .h_req_len     (h_req_len),
        .h_req_wr      (h_req_wr),
        .h_req_tag     (h_req_tag),
        .h_wr_data     (h_wr_data),
        .h_wr_next     (h_wr_next),
        .h_rd_data     (h_rd_data),
        .h_rd_valid    (h_rd_valid),
        .h_rd_tag      (h_rd_tag),
        .h_rd_last     (h_rd_last),
        .err_orphan_rd (err_orphan_rd),
        .app           (bus)
    );

    always #5 sdram_clk = ~sdram_clk;

    typedef struct { logic [aw-1:0] addr; int len; bit wr; logic [tw-1:0] tag; bit fin; } burst_t;
    typedef struct { logic [tw-1:0] tag; bit txn_last; bit burst_last; } rword_t;
    typedef struct { logic [aw-1:0] addr; int len; bit wr_n; } obs_t;

    burst_t        exp_burst[$];
    rword_t        rd_pend[$];
    logic [dw-1:0] hwq[$];
    obs_t          obs[$];
    int            pulls = 0;
    int            n_acks = 0;
    int            checks = 0;
    int            failures = 0;
    bit            ack_en = 1'b1;
    bit            ret_en = 1'b1;
    bit            force_rd = 1'b0;

    // Controller model: random acks, random write pulls, in-order read returns.
    initial begin : env
        burst_t        b;
        rword_t        w;
        bit            drove, nxt;
        logic [dw-1:0] d, wd;
        bus.app_req_ack     = 1'b0;
        bus.app_wr_next_req = 1'b0;
        bus.app_rd_data     = '0;
        bus.app_rd_valid    = 1'b0;
        bus.app_last_rd     = 1'b0;
        h_wr_data           = '0;
        forever begin
            @(negedge sdram_clk);
            #1;
            drove = 1'b0;
            bus.app_rd_valid = 1'b0;
            bus.app_last_rd  = 1'b0;
            if (force_rd) begin
                bus.app_rd_valid = 1'b1;
                bus.app_last_rd  = 1'b1;
                bus.app_rd_data  = $urandom;
            end else if (ret_en && rd_pend.size() != 0 && $urandom_range(3) != 0) begin
                w = rd_pend.pop_front();
                d = $urandom;
                bus.app_rd_valid = 1'b1;
                bus.app_last_rd  = w.burst_last;
                bus.app_rd_data  = d;
                drove = 1'b1;
            end
            nxt = (pulls > 0) && (hwq.size() != 0) && ($urandom_range(1) == 1);
            bus.app_wr_next_req = nxt;
            if (nxt) begin
                wd = hwq.pop_front();
                h_wr_data = wd;
                pulls--;
            end
            #1;
            if (drove) begin
                checks++;
                if (h_rd_valid !== 1'b1 || h_rd_data !== d || h_rd_tag !== w.tag || h_rd_last !== w.txn_last) begin
                    failures++;
                    $display("FAIL rd_word: got valid=%0b data=%h tag=%h last=%0b, expected valid=1 data=%h tag=%h last=%0b",
                             h_rd_valid, h_rd_data, h_rd_tag, h_rd_last, d, w.tag, w.txn_last);
                end
            end
            if (nxt) begin
                checks++;
                if (bus.app_wr_data !== wd || h_wr_next !== 1'b1) begin
                    failures++;
                    $display("FAIL wr_word: got data=%h next=%0b, expected data=%h next=1", bus.app_wr_data, h_wr_next, wd);
                end
            end
            bus.app_req_ack = ack_en && bus.app_req && ($urandom_range(2) != 0);
            if (bus.app_req_ack) begin
                n_acks++;
                obs.push_back('{addr: bus.app_req_addr, len: int'(bus.app_req_len), wr_n: bus.app_req_wr_n});
                checks++;
                if (exp_burst.size() == 0) begin
                    failures++;
                    $display("FAIL burst: unexpected burst addr=%h len=%0d wr_n=%0b", bus.app_req_addr, bus.app_req_len, bus.app_req_wr_n);
                end else begin
                    b = exp_burst.pop_front();
                    if (bus.app_req_addr !== b.addr || int'(bus.app_req_len) != b.len || bus.app_req_wr_n !== !b.wr) begin
                        failures++;
                        $display("FAIL burst: got addr=%h len=%0d wr_n=%0b, expected addr=%h len=%0d wr_n=%0b",
                                 bus.app_req_addr, bus.app_req_len, bus.app_req_wr_n, b.addr, b.len, !b.wr);
                    end
                    if (b.wr) pulls += b.len;
                    else for (int i = 0; i < b.len; i++)
                        rd_pend.push_back('{tag: b.tag, txn_last: b.fin && (i == b.len - 1), burst_last: (i == b.len - 1)});
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference split: min(remaining, MAX_BURST, room left in page); address wraps at 2^aw.
    task automatic host_req(input logic [aw-1:0] addr, input int len, input bit wr, input logic [tw-1:0] tag);
        longint a;
        int     rem, room, c, n;
        a = addr;
        rem = len + 1;
        while (rem > 0) begin
            room = COL_WORDS - int'(a % COL_WORDS);
            c = rem;
            if (c > MAX_BURST) c = MAX_BURST;
            if (c > room) c = room;
            exp_burst.push_back('{addr: aw'(a), len: c, wr: wr, tag: tag, fin: (rem == c)});
            a = (a + c) % (longint'(1) << aw);
            rem -= c;
        end
        if (wr) for (int i = 0; i <= len; i++) hwq.push_back($urandom);
        n = 0;
        @(negedge sdram_clk);
        while (!h_req_ready && n < 5000) begin
            @(negedge sdram_clk);
            n++;
        end
        checks++;
        if (!h_req_ready) begin
            failures++;
            $display("FAIL req_accept: h_req_ready=%0b, expected 1 within 5000 cycles", h_req_ready);
        end
        h_req_valid = 1'b1;
        h_req_addr  = addr;
        h_req_len   = 8'(len);
        h_req_wr    = wr;
        h_req_tag   = tag;
        @(negedge sdram_clk);
        h_req_valid = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge sdram_clk);
            #4;
            if (exp_burst.size() == 0 && rd_pend.size() == 0 && pulls == 0 && hwq.size() == 0 && h_req_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge sdram_clk);
        #4;
        checks++;
        if (h_req_ready !== 1'b0 || bus.app_req !== 1'b0 || err_orphan_rd !== 1'b0 || h_rd_valid !== 1'b0 || h_rd_last !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: ready=%0b app_req=%0b err=%0b rd_valid=%0b rd_last=%0b, expected all 0",
                     h_req_ready, bus.app_req, err_orphan_rd, h_rd_valid, h_rd_last);
        end
        checks++;
        if (bus.app_req_addr !== '0 || bus.app_req_len !== '0 || bus.app_req_wr_n !== 1'b0 || h_rd_tag !== '0) begin
            failures++;
            $display("FAIL reset_req_regs: addr=%h len=%0d wr_n=%0b tag=%h, expected 0", bus.app_req_addr, bus.app_req_len, bus.app_req_wr_n, h_rd_tag);
        end
        @(negedge sdram_clk);
        reset = 1'b0;
        @(negedge sdram_clk);
        #4;
        checks++;
        if (h_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset: got %0b, expected 1", h_req_ready);
        end
    endtask

    task automatic test_write();
        bit ok;
        obs.delete();
        host_req(26'h10, 3, 1'b1, 8'h21);
        wait_idle(ok);
        checks++;
        if (!ok || obs.size() != 1 || obs[0].addr !== 26'h10 || obs[0].len != 4 || obs[0].wr_n !== 1'b0) begin
            failures++;
            $display("FAIL write_4: done=%0b bursts=%0d first=(%h,%0d,%0b), expected 1 burst (10,4,0)", ok, obs.size(), obs[0].addr, obs[0].len, obs[0].wr_n);
        end
    endtask

    task automatic test_read_page_cross();
        bit ok;
        obs.delete();
        host_req(26'hF8, 19, 1'b0, 8'h5A);
        wait_idle(ok);
        checks++;
        if (!ok || obs.size() != 2 || obs[0].addr !== 26'hF8 || obs[0].len != 8 || obs[1].addr !== 26'h100 || obs[1].len != 12) begin
            failures++;
            $display("FAIL read_page_cross: done=%0b bursts=%0d (%h,%0d) (%h,%0d), expected (f8,8) (100,12)",
                     ok, obs.size(), obs[0].addr, obs[0].len, obs[1].addr, obs[1].len);
        end
    endtask

    task automatic test_read_split();
        bit ok;
        obs.delete();
        host_req(26'h0, 39, 1'b0, 8'hC3);
        wait_idle(ok);
        checks++;
        if (!ok || obs.size() != 3 || obs[0].len != 16 || obs[1].len != 16 || obs[2].len != 8 || obs[2].addr !== 26'h20 || obs[2].wr_n !== 1'b1) begin
            failures++;
            $display("FAIL read_split: done=%0b bursts=%0d lens=%0d,%0d,%0d, expected 3 bursts 16,16,8", ok, obs.size(), obs[0].len, obs[1].len, obs[2].len);
        end
    endtask

    task automatic test_tag_full();
        bit            ok;
        int            base;
        logic [aw-1:0] fifth;
        obs.delete();
        ret_en = 1'b0;
        base = n_acks;
        fifth = '0;
        for (int t = 1; t <= 5; t++) begin
            fifth = aw'($urandom);
            host_req(fifth, 0, 1'b0, tw'(t));
        end
        repeat (10) @(negedge sdram_clk);
        #4;
        checks++;
        if (n_acks - base != TAG_DEPTH || bus.app_req !== 1'b0) begin
            failures++;
            $display("FAIL tag_full_stall: acks=%0d app_req=%0b, expected acks=%0d app_req=0", n_acks - base, bus.app_req, TAG_DEPTH);
        end
        ret_en = 1'b1;
        wait_idle(ok);
        checks++;
        if (!ok || n_acks - base != 5 || obs[4].addr !== fifth) begin
            failures++;
            $display("FAIL tag_full_release: done=%0b acks=%0d addr=%h, expected acks=5 addr=%h", ok, n_acks - base, obs[4].addr, fifth);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        obs.delete();
        host_req(26'h3FFFFFE, 3, 1'b1, 8'h77);
        wait_idle(ok);
        checks++;
        if (!ok || obs.size() != 2 || obs[0].addr !== 26'h3FFFFFE || obs[0].len != 2 || obs[1].addr !== 26'h0 || obs[1].len != 2) begin
            failures++;
            $display("FAIL addr_wrap: done=%0b bursts=%0d (%h,%0d) (%h,%0d), expected (3fffffe,2) (0,2)",
                     ok, obs.size(), obs[0].addr, obs[0].len, obs[1].addr, obs[1].len);
        end
    endtask

    task automatic test_back_to_back();
        bit            ok;
        logic [aw-1:0] a;
        int            len;
        for (int i = 0; i < 12; i++) begin
            a = aw'($urandom);
            if ($urandom_range(1) == 1) a[7:0] = 8'(8'hF0 + $urandom_range(15));
            len = (i == 5) ? 255 : $urandom_range(40);
            host_req(a, len, $urandom_range(1) == 1, tw'($urandom));
        end
        wait_idle(ok);
        checks++;
        if (!ok || err_orphan_rd !== 1'b0) begin
            failures++;
            $display("FAIL back_to_back: done=%0b err_orphan_rd=%0b, expected done=1 err=0", ok, err_orphan_rd);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        ack_en = 1'b0;
        host_req(26'h1234, 5, 1'b0, 8'hA5);
        n = 0;
        while (bus.app_req !== 1'b1 && n < 50) begin
            @(negedge sdram_clk);
            #4;
            n++;
        end
        checks++;
        if (bus.app_req !== 1'b1) begin
            failures++;
            $display("FAIL issue_reached: app_req=%0b, expected 1", bus.app_req);
        end
        @(negedge sdram_clk);
        reset = 1'b1;
        @(negedge sdram_clk);
        #4;
        checks++;
        if (bus.app_req !== 1'b0 || h_req_ready !== 1'b0 || bus.app_req_len !== '0 || err_orphan_rd !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: app_req=%0b ready=%0b len=%0d err=%0b, expected all 0", bus.app_req, h_req_ready, bus.app_req_len, err_orphan_rd);
        end
        exp_burst.delete();
        ack_en = 1'b1;
        @(negedge sdram_clk);
        reset = 1'b0;
        force_rd = 1'b1;
        #4;
        checks++;
        if (h_rd_valid !== 1'b0 || h_rd_last !== 1'b0 || h_rd_tag !== '0 || h_rd_data !== bus.app_rd_data) begin
            failures++;
            $display("FAIL orphan_return: rd_valid=%0b rd_last=%0b tag=%h, expected 0 0 0 with data passthrough", h_rd_valid, h_rd_last, h_rd_tag);
        end
        @(negedge sdram_clk);
        force_rd = 1'b0;
        #4;
        checks++;
        if (err_orphan_rd !== 1'b1 || h_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL orphan_flag: err=%0b ready=%0b, expected err=1 ready=1", err_orphan_rd, h_req_ready);
        end
        repeat (3) @(negedge sdram_clk);
        #4;
        checks++;
        if (err_orphan_rd !== 1'b1 || h_rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL orphan_sticky: err=%0b rd_valid=%0b, expected err=1 rd_valid=0", err_orphan_rd, h_rd_valid);
        end
    endtask

    initial begin : main
        h_req_valid = 1'b0;
        h_req_addr  = '0;
        h_req_len   = '0;
        h_req_wr    = 1'b0;
        h_req_tag   = '0;
        test_reset();
        test_write();
        test_read_page_cross();
        test_read_split();
        test_tag_full();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
